// File: rtl/sram_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage loads/stores, one transaction at a time.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX consecutive losses.
module sram_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [1:0]  state;
    logic        owner;
    logic [3:0]  starve_cnt;
    logic [31:0] resp_q;
    logic        in_idle;
    logic        force_inst;

    // Grants are combinational so a master sees addr_ok in the same cycle it asks.
    assign in_idle      = resetn && (state == S_IDLE);
    assign force_inst   = inst_req && (starve_cnt == STARVE_LIM);
    assign data_addr_ok = in_idle && data_req && !force_inst;
    assign inst_addr_ok = in_idle && inst_req && !data_addr_ok;

    assign mem_req      = (state == S_REQ);
    assign inst_data_ok = (state == S_DONE) && !owner;
    assign data_data_ok = (state == S_DONE) && owner;
    assign inst_rdata   = resp_q;
    assign data_rdata   = resp_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            starve_cnt <= 4'd0;
            resp_q     <= 32'd0;
            mem_wr     <= 1'b0;
            mem_wstrb  <= 4'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (data_addr_ok) begin
                        owner     <= 1'b1;
                        mem_wr    <= data_wr;
                        mem_wstrb <= data_wr ? data_wstrb : 4'd0;
                        mem_addr  <= data_addr & WORD_MASK;
                        mem_wdata <= data_wdata;
                        state     <= S_REQ;
                        if (inst_req && (starve_cnt != STARVE_LIM))
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (inst_addr_ok) begin
                        owner      <= 1'b0;
                        mem_wr     <= 1'b0;
                        mem_wstrb  <= 4'd0;
                        mem_addr   <= inst_addr & WORD_MASK;
                        mem_wdata  <= 32'd0;
                        starve_cnt <= 4'd0;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack)
                        state <= S_RESP;
                end
                S_RESP: begin
                    // A coincident mem_ack here is stray and has no effect.
                    if (mem_rvalid) begin
                        resp_q <= mem_rdata;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
